// File: rtl/pic_core_param.sv
// pic_core_param: NUM_IRQ-channel 8259-style interrupt controller core (IRR, priority resolver, ISR, INTA sequencer).
// Latency: irq edge -> irr +1 cycle -> int_out +2 cycles; first inta -> isr +1; second inta -> vec_valid +1.
// Backpressure: none; an acknowledge sequence parks in WAIT2 until the second inta arrives.
module pic_core_param #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_IRQ-1:0] i_irq_lines,
  input  logic               i_cfg_level,
  input  logic               i_cfg_rotate,
  input  logic               i_cfg_auto_eoi,
  input  logic [NUM_IRQ-1:0] i_imr,
  input  logic               i_eoi,
  input  logic               i_inta,
  output logic               o_int_out,
  output logic               o_vec_valid,
  output logic [ID_W-1:0]    o_vec_id,
  output logic               o_vec_spurious,
  output logic [NUM_IRQ-1:0] o_irr,
  output logic [NUM_IRQ-1:0] o_isr
);

  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_IRQ - 1);
  localparam logic [ID_W:0]      N_EXT   = NUM_IRQ[ID_W:0];
  localparam logic [ID_W:0]      ONE_EXT = {{ID_W{1'b0}}, 1'b1};
  localparam logic [NUM_IRQ-1:0] ONE_HOT = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_WAIT2 = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_IRQ-1:0]  r_irq_prev;
  logic [NUM_IRQ-1:0]  r_irr;
  logic [NUM_IRQ-1:0]  r_isr;
  logic [ID_W-1:0]     r_low_id;
  logic [ID_W-1:0]     r_ack_id;
  logic                r_ack_spur;
  logic                r_int_out;
  logic                r_vec_valid;
  logic [ID_W-1:0]     r_vec_id;
  logic                r_vec_spur;

  // Highest-priority set bit of vec, where priority starts at (low+1) mod NUM_IRQ.
  // Returns {found, rank, id}; rank 0 is the highest priority position.
  function automatic logic [2*ID_W:0] f_resolve(input logic [NUM_IRQ-1:0] vec,
                                                input logic [ID_W-1:0]    low);
    logic [2*NUM_IRQ-1:0] dbl;
    logic [ID_W:0]        sum;
    logic                 found;
    logic [ID_W-1:0]      rank;
    dbl   = {vec, vec} >> ({1'b0, low} + ONE_EXT);
    found = 1'b0;
    rank  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        found = 1'b1;
        rank  = ID_W'(k);
      end
    end
    sum = {1'b0, low} + ONE_EXT + {1'b0, rank};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return {found, rank, sum[ID_W-1:0]};
  endfunction

  logic [2*ID_W:0]    w_cand;
  logic [2*ID_W:0]    w_srv;
  logic               w_cand_vld;
  logic [ID_W-1:0]    w_cand_rank;
  logic [ID_W-1:0]    w_cand_id;
  logic               w_srv_vld;
  logic [ID_W-1:0]    w_srv_rank;
  logic [ID_W-1:0]    w_srv_id;
  logic               w_req;
  logic               w_ack1;
  logic               w_ack2;
  logic               w_int_ok;
  logic               w_auto;
  logic               w_eoi_hit;
  logic [NUM_IRQ-1:0] w_ack_set;
  logic [NUM_IRQ-1:0] w_irr_clr;
  logic [NUM_IRQ-1:0] w_auto_clr;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic [NUM_IRQ-1:0] w_irr_next;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [ID_W-1:0]    w_low_next;

  assign w_cand      = f_resolve(r_irr & ~i_imr, r_low_id);
  assign w_cand_vld  = w_cand[2*ID_W];
  assign w_cand_rank = w_cand[2*ID_W-1:ID_W];
  assign w_cand_id   = w_cand[ID_W-1:0];
  assign w_srv       = f_resolve(r_isr, r_low_id);
  assign w_srv_vld   = w_srv[2*ID_W];
  assign w_srv_rank  = w_srv[2*ID_W-1:ID_W];
  assign w_srv_id    = w_srv[ID_W-1:0];

  // Masked in-service bits still block a lower-or-equal priority request.
  assign w_req = w_cand_vld && (!w_srv_vld || (w_cand_rank < w_srv_rank));

  assign w_auto     = w_ack2 && i_cfg_auto_eoi && !r_ack_spur;
  assign w_eoi_hit  = i_eoi && w_srv_vld;
  assign w_ack_set  = (w_ack1 && w_cand_vld) ? (ONE_HOT << w_cand_id) : '0;
  assign w_irr_clr  = i_cfg_level ? '0 : w_ack_set;
  assign w_auto_clr = w_auto ? (ONE_HOT << r_ack_id) : '0;
  assign w_eoi_clr  = w_eoi_hit ? (ONE_HOT << w_srv_id) : '0;

  // Edge mode latches rising edges until acknowledged; level mode follows the lines.
  assign w_irr_next = i_cfg_level ? i_irq_lines
                                   : ((r_irr | (i_irq_lines & ~r_irq_prev)) & ~w_irr_clr);
  assign w_isr_next = (r_isr & ~w_eoi_clr & ~w_auto_clr) | w_ack_set;

  // Rotation base: auto-EOI is applied after a same-cycle EOI, so it wins.
  always_comb begin
    w_low_next = r_low_id;
    if (!i_cfg_rotate)  w_low_next = LAST_ID;
    else if (w_auto)    w_low_next = r_ack_id;
    else if (w_eoi_hit) w_low_next = w_srv_id;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // FSM next state: each inta pulse advances the two-step acknowledge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_inta) w_state_next = S_WAIT2;
      S_WAIT2: if (i_inta) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: which acknowledge step is happening and whether int_out may be raised.
  always_comb begin
    w_ack1   = 1'b0;
    w_ack2   = 1'b0;
    w_int_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ack1   = i_inta;
        w_int_ok = !i_inta;
      end
      S_WAIT2: w_ack2 = i_inta;
      default: ;
    endcase
  end

  // Request/service registers, rotation base, latched vector and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_irq_prev  <= '0;
      r_irr       <= '0;
      r_isr       <= '0;
      r_low_id    <= LAST_ID;
      r_ack_id    <= '0;
      r_ack_spur  <= 1'b0;
      r_int_out   <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_id    <= '0;
      r_vec_spur  <= 1'b0;
    end else begin
      r_irq_prev  <= i_irq_lines;
      r_irr       <= w_irr_next;
      r_isr       <= w_isr_next;
      r_low_id    <= w_low_next;
      r_int_out   <= w_int_ok && w_req;
      r_vec_valid <= w_ack2;
      if (w_ack1) begin
        r_ack_id   <= w_cand_vld ? w_cand_id : LAST_ID;
        r_ack_spur <= !w_cand_vld;
      end
      if (w_ack2) begin
        r_vec_id   <= r_ack_id;
        r_vec_spur <= r_ack_spur;
      end
    end
  end

  assign o_int_out      = r_int_out;
  assign o_vec_valid    = r_vec_valid;
  assign o_vec_id       = r_vec_id;
  assign o_vec_spurious = r_vec_spur;
  assign o_irr          = r_irr;
  assign o_isr          = r_isr;

endmodule

// File: tb/tb_pic_core_param.sv
// tb_pic_core_param: directed scenarios plus randomized traffic on an 8-channel core compared
// every cycle against a behavioural model; a 16-channel core gets directed literal checks.
// Inputs change 2 time units after the rising edge; outputs are compared on the falling edge.
module tb_pic_core_param;

  localparam int MN = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel DUT signals
  logic         reset_n = 1'b0;
  logic [7:0]   irq_lines = '0;
  logic         cfg_level = 1'b0, cfg_rotate = 1'b0, cfg_auto_eoi = 1'b0;
  logic [7:0]   imr = '0;
  logic         eoi = 1'b0, inta = 1'b0;
  logic         o_int_out, o_vec_valid, o_vec_spurious;
  logic [2:0]   o_vec_id;
  logic [7:0]   o_irr, o_isr;

  // 16-channel DUT signals
  logic         b_reset_n = 1'b0;
  logic [15:0]  b_irq = '0;
  logic         b_level = 1'b0, b_rot = 1'b0, b_auto = 1'b0;
  logic [15:0]  b_imr = '0;
  logic         b_eoi = 1'b0, b_inta = 1'b0;
  logic         b_int, b_vv, b_vsp;
  logic [3:0]   b_vid;
  logic [15:0]  b_irr, b_isr;

  pic_core_param #(.NUM_IRQ(8), .ID_W(3)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_irq_lines(irq_lines),
    .i_cfg_level(cfg_level), .i_cfg_rotate(cfg_rotate), .i_cfg_auto_eoi(cfg_auto_eoi),
    .i_imr(imr), .i_eoi(eoi), .i_inta(inta),
    .o_int_out(o_int_out), .o_vec_valid(o_vec_valid), .o_vec_id(o_vec_id),
    .o_vec_spurious(o_vec_spurious), .o_irr(o_irr), .o_isr(o_isr)
  );

  pic_core_param #(.NUM_IRQ(16), .ID_W(4)) dut16 (
    .i_clk(clk), .i_reset_n(b_reset_n), .i_irq_lines(b_irq),
    .i_cfg_level(b_level), .i_cfg_rotate(b_rot), .i_cfg_auto_eoi(b_auto),
    .i_imr(b_imr), .i_eoi(b_eoi), .i_inta(b_inta),
    .o_int_out(b_int), .o_vec_valid(b_vv), .o_vec_id(b_vid),
    .o_vec_spurious(b_vsp), .o_irr(b_irr), .o_isr(b_isr)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model of the 8-channel core ----------------
  bit [7:0] m_irr, m_isr, m_prev;
  int       m_low, m_lid, m_vid;
  bit       m_wait, m_sp, m_int, m_vv, m_vsp;

  // Priority position of id when the lowest-priority id is low (0 = highest).
  function automatic int rank_of(input int id, input int low);
    return (id - low - 1 + 2 * MN) % MN;
  endfunction

  // Highest-priority set id in v, or -1 when none is set.
  function automatic int best(input bit [7:0] v, input int low);
    for (int r = 0; r < MN; r++) begin
      int id;
      id = (low + 1 + r) % MN;
      if (v[id[2:0]]) return id;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int cand, srv;
    bit nint;
    if (!reset_n) begin
      m_irr = '0; m_isr = '0; m_prev = '0; m_low = MN - 1;
      m_wait = 0; m_lid = 0; m_sp = 0;
      m_int = 0; m_vv = 0; m_vid = 0; m_vsp = 0;
    end else begin
      cand = best(m_irr & ~imr, m_low);
      srv  = best(m_isr, m_low);
      nint = !m_wait && !inta && cand >= 0 &&
             (srv < 0 || rank_of(cand, m_low) < rank_of(srv, m_low));
      m_vv = 0;
      if (cfg_level) m_irr = irq_lines;
      else           m_irr = m_irr | (irq_lines & ~m_prev);
      if (eoi && srv >= 0) begin
        m_isr[srv[2:0]] = 1'b0;
        if (cfg_rotate) m_low = srv;
      end
      if (!m_wait && inta) begin
        if (cand >= 0) begin
          m_isr[cand[2:0]] = 1'b1;
          if (!cfg_level) m_irr[cand[2:0]] = 1'b0;
          m_lid = cand;
          m_sp  = 0;
        end else begin
          m_lid = MN - 1;
          m_sp  = 1;
        end
        m_wait = 1;
      end else if (m_wait && inta) begin
        m_vv  = 1;
        m_vid = m_lid;
        m_vsp = m_sp;
        if (cfg_auto_eoi && !m_sp) begin
          m_isr[m_lid[2:0]] = 1'b0;
          if (cfg_rotate) m_low = m_lid;
        end
        m_wait = 0;
      end
      if (!cfg_rotate) m_low = MN - 1;
      m_prev = irq_lines;
      m_int  = nint;
    end
  end

  // Every-cycle comparison of the 8-channel core against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_int_out",  32'(o_int_out),      32'(m_int));
      chk("m_vec_vld",  32'(o_vec_valid),    32'(m_vv));
      chk("m_vec_id",   32'(o_vec_id),       32'(m_vid));
      chk("m_vec_spur", 32'(o_vec_spurious), 32'(m_vsp));
      chk("m_irr",      32'(o_irr),          32'(m_irr));
      chk("m_isr",      32'(o_isr),          32'(m_isr));
    end
  end

  task automatic do_reset();
    eoi = 0; inta = 0; imr = '0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic pulse_inta();
    inta = 1; tick(); inta = 0;
  endtask

  task automatic pulse_inta16();
    b_inta = 1; tick(); b_inta = 0;
  endtask

  initial begin
    // ---- reset values ----
    tick(); tick();
    chk("rst_int_out", 32'(o_int_out), 0);
    chk("rst_vec_vld", 32'(o_vec_valid), 0);
    chk("rst_vec_id",  32'(o_vec_id), 0);
    chk("rst_irr",     32'(o_irr), 0);
    chk("rst_isr",     32'(o_isr), 0);
    reset_n = 1;

    // ---- S1: edge on line 5 ----
    irq_lines = 8'h20; tick();
    chk("s1_irr",      32'(o_irr), 'h20);
    chk("s1_int_t1",   32'(o_int_out), 0);
    tick();
    chk("s1_int_t2",   32'(o_int_out), 1);
    pulse_inta();
    chk("s1_int_ack",  32'(o_int_out), 0);
    chk("s1_isr",      32'(o_isr), 'h20);
    pulse_inta();
    chk("s1_vv",       32'(o_vec_valid), 1);
    chk("s1_vid",      32'(o_vec_id), 5);
    chk("s1_spur",     32'(o_vec_spurious), 0);
    tick();
    chk("s1_vv_pulse", 32'(o_vec_valid), 0);

    // ---- S2: fixed priority, lines 2 and 6, EOI unblocks 6 ----
    irq_lines = '0; do_reset();
    irq_lines = 8'h44; tick(); tick();
    chk("s2_int",      32'(o_int_out), 1);
    pulse_inta();
    chk("s2_isr",      32'(o_isr), 'h04);
    chk("s2_irr",      32'(o_irr), 'h40);
    pulse_inta();
    chk("s2_vid",      32'(o_vec_id), 2);
    tick(); tick(); tick();
    chk("s2_blocked",  32'(o_int_out), 0);
    eoi = 1; tick(); eoi = 0;
    chk("s2_eoi_isr",  32'(o_isr), 0);
    tick();
    chk("s2_int6",     32'(o_int_out), 1);
    pulse_inta(); pulse_inta();
    chk("s2_vid6",     32'(o_vec_id), 6);

    // ---- S3: rotate + auto-EOI, level mode, all lines held ----
    irq_lines = '0;
    cfg_level = 1; cfg_rotate = 1; cfg_auto_eoi = 1;
    do_reset();
    irq_lines = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int w = 0; w < 12 && !o_int_out; w++) tick();
      chk("s3_int_wait", 32'(o_int_out), 1);
      pulse_inta();
      chk("s3_isr_set",  32'(o_isr), 32'(1) << (k % MN));
      pulse_inta();
      chk("s3_vid",      32'(o_vec_id), k % MN);
      chk("s3_isr_clr",  32'(o_isr), 0);
    end

    // ---- S4: request masked before acknowledge -> spurious ----
    irq_lines = '0; cfg_level = 0; cfg_rotate = 0; cfg_auto_eoi = 0;
    do_reset();
    irq_lines = 8'h08; tick(); tick();
    imr = 8'h08; tick();
    pulse_inta(); pulse_inta();
    chk("s4_vv",   32'(o_vec_valid), 1);
    chk("s4_vid",  32'(o_vec_id), 7);
    chk("s4_spur", 32'(o_vec_spurious), 1);
    chk("s4_isr",  32'(o_isr), 0);
    chk("s4_irr",  32'(o_irr), 'h08);
    imr = '0;

    // ---- S5: reset in WAIT2 ----
    irq_lines = '0; do_reset();
    irq_lines = 8'h01; tick(); tick();
    pulse_inta();
    chk("s5_isr", 32'(o_isr), 'h01);
    irq_lines = '0; reset_n = 0; tick();
    chk("s5_int", 32'(o_int_out), 0);
    chk("s5_irr", 32'(o_irr), 0);
    chk("s5_isr0", 32'(o_isr), 0);
    reset_n = 1; tick();
    pulse_inta(); pulse_inta();
    chk("s5_vid",  32'(o_vec_id), 7);
    chk("s5_spur", 32'(o_vec_spurious), 1);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_lines = 8'($urandom);
      if ($urandom_range(0, 7) == 0) imr = 8'($urandom & $urandom);
      if ($urandom_range(0, 99) == 0) {cfg_level, cfg_rotate, cfg_auto_eoi} = 3'($urandom);
      eoi     = ($urandom_range(0, 9) == 0);
      inta    = ($urandom_range(0, 4) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    eoi = 0; inta = 0; reset_n = 1;

    // ---- 16 channels: EOI and second inta together ----
    b_rot = 1; b_auto = 0; b_level = 0;
    b_reset_n = 0; tick(); tick(); b_reset_n = 1;
    b_irq = 16'h0200; tick(); tick();
    chk("b_int9", 32'(b_int), 1);
    pulse_inta16(); pulse_inta16();
    chk("b_vid9", 32'(b_vid), 9);
    chk("b_isr9", 32'(b_isr), 'h0200);
    b_irq = 16'h1200; tick(); tick();
    chk("b_irr12",   32'(b_irr), 'h1000);
    chk("b_blocked", 32'(b_int), 0);
    pulse_inta16();
    chk("b_isr_nest", 32'(b_isr), 'h1200);
    b_auto = 1; b_eoi = 1; b_inta = 1; tick(); b_eoi = 0; b_inta = 0;
    chk("b_vv12",  32'(b_vv), 1);
    chk("b_vid12", 32'(b_vid), 12);
    chk("b_isr0",  32'(b_isr), 0);
    b_irq = 16'h5204; tick(); tick();
    chk("b_irr_2_14", 32'(b_irr), 'h4004);
    chk("b_int_rot",  32'(b_int), 1);
    pulse_inta16(); pulse_inta16();
    chk("b_vid14", 32'(b_vid), 14);
    chk("b_isr_a", 32'(b_isr), 0);
    for (int w = 0; w < 12 && !b_int; w++) tick();
    chk("b_int_wait", 32'(b_int), 1);
    pulse_inta16(); pulse_inta16();
    chk("b_vid2", 32'(b_vid), 2);

    tick();
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
